// File: rtl/fifo_sync_param.sv
// Single-clock partial-sum FIFO with occupancy count, threshold flags,
// optional first-word-fall-through read, sync flush and sticky errors.
module fifo_sync_param #(
   parameter int sum_bw   = 22,
   parameter int ptr_len  = 4,
   parameter bit fwft     = 1'b0,
   parameter int af_level = (2**ptr_len) - 2,
   parameter int ae_level = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              wr,
   input  logic [sum_bw-1:0] in,
   input  logic              rd,
   output logic [sum_bw-1:0] out,
   output logic              out_valid,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ptr_len:0]  count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int DEPTH = 2**ptr_len;
   localparam logic [ptr_len:0] AF = (ptr_len+1)'(af_level);
   localparam logic [ptr_len:0] AE = (ptr_len+1)'(ae_level);

   logic [sum_bw-1:0] mem_q [DEPTH];
   logic [ptr_len:0]  wr_ptr_q, wr_ptr_d;
   logic [ptr_len:0]  rd_ptr_q, rd_ptr_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              wr_ok, rd_ok;
   logic [ptr_len-1:0] wa, ra;

   assign wa = wr_ptr_q[ptr_len-1:0];
   assign ra = rd_ptr_q[ptr_len-1:0];

   // Flags decode only registered pointers, never the live requests.
   assign count        = wr_ptr_q - rd_ptr_q;
   assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
   assign fifo_full    = (wa == ra) &&
                         (wr_ptr_q[ptr_len] != rd_ptr_q[ptr_len]);
   assign almost_full  = (count >= AF);
   assign almost_empty = (count <= AE);
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   always_comb begin
      wr_ok    = wr & ~fifo_full & ~flush;
      rd_ok    = rd & ~fifo_empty & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      end
      ovf_d = (ovf_q & ~clr_err) | (wr & fifo_full & ~flush);
      unf_d = (unf_q & ~clr_err) | (rd & fifo_empty & ~flush);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wa] <= in;
   end

   if (fwft) begin : g_fwft
      assign out       = fifo_empty ? '0 : mem_q[ra];
      assign out_valid = ~fifo_empty;
   end else begin : g_std
      logic [sum_bw-1:0] out_q;
      logic              out_valid_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
         end else begin
            if (rd_ok) out_q <= mem_q[ra];
            out_valid_q <= rd_ok;
         end
      end

      assign out       = out_q;
      assign out_valid = out_valid_q;
   end

endmodule
